// File: rtl/uart_receiver_pkg.sv
// uart_receiver_package
// Shared constants for the UART receive path:
//   - FSM state encodings (IDLE, START, DATA, STOP)
//   - baud-rate table indexed by the 2-bit baudrate_select code
//   - clocks_per_bit(): integer-truncated clock cycles per serial bit
//   - receive FIFO depth plus pointer and count widths
package uart_receiver_package;

  // Receiver FSM states
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  // Baud rates selected by codes 0..3
  localparam int unsigned BAUD_TABLE [4] = '{9600, 19200, 57600, 115200};

  // Receive FIFO geometry; the 6-bit threshold input ties the depth to 64
  localparam int unsigned FIFO_ENTRIES     = 64;
  localparam int unsigned FIFO_PTR_WIDTH   = 6;
  localparam int unsigned FIFO_COUNT_WIDTH = 7;

  function automatic int unsigned clocks_per_bit(input logic [1:0] select,
                                                 input int unsigned freq);
    return freq / BAUD_TABLE[select];
  endfunction

endpackage

// File: rtl/uart_receiver_fifo.sv
// uart_receiver_fifo
// Synchronous show-ahead FIFO, 8 bits x 64 entries.
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous active-low reset; empties the FIFO
//   write_enable push write_data (accepted when write_ready)
//   write_data   byte to push
//   read_enable  pop the head; ignored when empty
//   threshold    fullness threshold, 0 means 64
//   read_data    head entry (0 while empty)
//   empty        count == 0
//   full         count >= threshold
//   write_ready  a write this cycle would be stored
module uart_receiver_fifo
  import uart_receiver_package::*;
#(
  parameter int unsigned DEPTH = FIFO_ENTRIES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       write_enable,
  input  logic [7:0] write_data,
  input  logic       read_enable,
  input  logic [5:0] threshold,
  output logic [7:0] read_data,
  output logic       empty,
  output logic       full,
  output logic       write_ready
);

  logic [7:0]                  mem [DEPTH];
  logic [FIFO_PTR_WIDTH-1:0]   write_ptr;
  logic [FIFO_PTR_WIDTH-1:0]   read_ptr;
  logic [FIFO_COUNT_WIDTH-1:0] count;
  logic [FIFO_COUNT_WIDTH-1:0] limit;
  logic                        do_read;
  logic                        do_write;

  assign empty   = (count == '0);
  assign do_read = read_enable && !empty;

  // A pop in the same cycle frees a slot, so a write at full is still taken
  assign write_ready = (count != FIFO_COUNT_WIDTH'(DEPTH)) || do_read;
  assign do_write    = write_enable && write_ready;

  assign limit = (threshold == '0) ? FIFO_COUNT_WIDTH'(DEPTH)
                                   : FIFO_COUNT_WIDTH'(threshold);
  assign full  = (count >= limit);

  // Show-ahead head; forced to 0 while empty so reset presents data = 0
  assign read_data = empty ? 8'h00 : mem[read_ptr];

  // Storage array has no reset; only pointers and count define validity
  always_ff @(posedge clock) begin
    if (do_write) begin
      mem[write_ptr] <= write_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      write_ptr <= '0;
      read_ptr  <= '0;
      count     <= '0;
    end else begin
      if (do_write) begin
        write_ptr <= write_ptr + FIFO_PTR_WIDTH'(1);
      end
      if (do_read) begin
        read_ptr <= read_ptr + FIFO_PTR_WIDTH'(1);
      end
      case ({do_write, do_read})
        2'b10:   count <= count + FIFO_COUNT_WIDTH'(1);
        2'b01:   count <= count - FIFO_COUNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver
// 8N1 UART receiver (LSB first) with four selectable baud rates feeding a
// 64-entry show-ahead receive FIFO.
// Ports:
//   clock                  system clock, rising edge
//   reset                  synchronous active-low reset
//   data_in                serial line, idle high, asynchronous to clock
//   read_enable            pop the FIFO head
//   buffer_full_threshold  fullness threshold, 0 means 64
//   baudrate_select        0=9600, 1=19200, 2=57600, 3=115200
//   data                   FIFO head, valid when buffer_empty = 0
//   buffer_empty           FIFO holds no bytes
//   buffer_full            FIFO count >= threshold
//   framing_error          1-cycle pulse: stop bit read as 0, byte discarded
//   overrun_error          1-cycle pulse: byte arrived with FIFO full, dropped
module uart_receiver
  import uart_receiver_package::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 50_000_000,
  parameter int unsigned FIFO_DEPTH      = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       data_in,
  input  logic       read_enable,
  input  logic [5:0] buffer_full_threshold,
  input  logic [1:0] baudrate_select,
  output logic [7:0] data,
  output logic       buffer_empty,
  output logic       buffer_full,
  output logic       framing_error,
  output logic       overrun_error
);

  // Slowest rate has the longest bit period and sizes the counters
  localparam int unsigned PERIOD_WIDTH = $clog2(clocks_per_bit(2'd0, CLOCK_FREQUENCY) + 1);
  localparam logic [PERIOD_WIDTH-1:0] ONE = PERIOD_WIDTH'(1);

  logic                    sync_meta;
  logic                    rx;
  logic                    rx_prev;
  logic [1:0]              state;
  logic [PERIOD_WIDTH-1:0] count;
  logic [PERIOD_WIDTH-1:0] period;
  logic [PERIOD_WIDTH-1:0] half;
  logic [PERIOD_WIDTH-1:0] next_period;
  logic [2:0]              bit_index;
  logic [7:0]              shift;
  logic                    half_done;
  logic                    bit_done;
  logic                    stop_sample;
  logic                    write_ready;

  assign next_period = PERIOD_WIDTH'(clocks_per_bit(baudrate_select, CLOCK_FREQUENCY));
  assign half_done   = (count == half - ONE);
  assign bit_done    = (count == period - ONE);
  assign stop_sample = (state == STOP) && bit_done;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection;
  // all flops reset to the idle-high line level so reset never fakes a start
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_meta <= 1'b1;
      rx        <= 1'b1;
      rx_prev   <= 1'b1;
    end else begin
      sync_meta <= data_in;
      rx        <= sync_meta;
      rx_prev   <= rx;
    end
  end

  // Frame FSM. The bit period is captured at the start edge so a mid-frame
  // baudrate_select change only affects the next frame. STOP returns to
  // IDLE on the sample edge, leaving half a stop bit to catch the next start.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      count         <= '0;
      period        <= '0;
      half          <= '0;
      bit_index     <= '0;
      shift         <= '0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_prev && !rx) begin
            period <= next_period;
            half   <= next_period >> 1;
            count  <= '0;
            state  <= START;
          end
        end
        START: begin
          if (half_done) begin
            count     <= '0;
            bit_index <= '0;
            state     <= rx ? IDLE : DATA;
          end else begin
            count <= count + ONE;
          end
        end
        DATA: begin
          if (bit_done) begin
            count            <= '0;
            shift[bit_index] <= rx;
            if (bit_index == 3'd7) begin
              state <= STOP;
            end else begin
              bit_index <= bit_index + 3'd1;
            end
          end else begin
            count <= count + ONE;
          end
        end
        STOP: begin
          if (bit_done) begin
            count <= '0;
            state <= IDLE;
            if (!rx) begin
              framing_error <= 1'b1;
            end else if (!write_ready) begin
              overrun_error <= 1'b1;
            end
          end else begin
            count <= count + ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_receiver_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) fifo (
    .clock       (clock),
    .reset       (reset),
    .write_enable(stop_sample && rx),
    .write_data  (shift),
    .read_enable (read_enable),
    .threshold   (buffer_full_threshold),
    .read_data   (data),
    .empty       (buffer_empty),
    .full        (buffer_full),
    .write_ready (write_ready)
  );

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver
// Self-checking bench for uart_receiver. A behavioural serial driver sends
// 8N1 frames; a queue-based model tracks expected FIFO contents, fullness
// and error-pulse counts from the frame-level rules of the receiver.
module tb_uart_receiver;

  localparam int unsigned CLK_HZ   = 1_152_000;
  localparam int unsigned BAUDS [4] = '{9600, 19200, 57600, 115200};

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       data_in = 1'b1;
  logic       read_enable = 1'b0;
  logic [5:0] buffer_full_threshold = 6'd4;
  logic [1:0] baudrate_select = 2'd3;
  logic [7:0] data;
  logic       buffer_empty;
  logic       buffer_full;
  logic       framing_error;
  logic       overrun_error;

  int compared   = 0;
  int mismatched = 0;

  // Error-pulse monitor: total high cycles and number of distinct pulses
  int   fe_cycles = 0;
  int   fe_pulses = 0;
  int   oe_cycles = 0;
  int   oe_pulses = 0;
  logic fe_prev   = 1'b0;
  logic oe_prev   = 1'b0;

  // Reference model state
  logic [7:0] exp_q [$];
  int         exp_fe = 0;
  int         exp_oe = 0;
  logic [7:0] v;

  uart_receiver #(
    .CLOCK_FREQUENCY(CLK_HZ),
    .FIFO_DEPTH     (64)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .data_in              (data_in),
    .read_enable          (read_enable),
    .buffer_full_threshold(buffer_full_threshold),
    .baudrate_select      (baudrate_select),
    .data                 (data),
    .buffer_empty         (buffer_empty),
    .buffer_full          (buffer_full),
    .framing_error        (framing_error),
    .overrun_error        (overrun_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (framing_error) fe_cycles++;
    if (framing_error && !fe_prev) fe_pulses++;
    if (overrun_error) oe_cycles++;
    if (overrun_error && !oe_prev) oe_pulses++;
    fe_prev = framing_error;
    oe_prev = overrun_error;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int bitPeriod(input logic [1:0] sel);
    return int'(CLK_HZ / BAUDS[sel]);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one frame: start, 8 data bits LSB first, stop_bit. baudrate_select
  // is switched to mid_sel during the data bits and restored for the stop bit.
  // With read_at_stop, read_enable is raised for the edge that samples the
  // stop bit: 2 synchronizer edges + 1 detect edge + half + 9 bit periods
  // after the edge that launched the start bit.
  task automatic applyStimulus(input logic [7:0] value, input logic [1:0] sel,
                               input logic stop_bit, input logic [1:0] mid_sel,
                               input bit read_at_stop);
    int p;
    logic [9:0] frame;
    p     = bitPeriod(sel);
    frame = {stop_bit, value, 1'b0};
    baudrate_select = sel;
    for (int b = 0; b < 10; b++) begin
      @(posedge clock); #1;
      data_in = frame[b];
      if (b == 5) baudrate_select = mid_sel;
      if (b == 9) baudrate_select = sel;
      if (b == 9 && read_at_stop) begin
        repeat (p / 2 + 2) @(posedge clock);
        #1 read_enable = 1'b1;
        @(posedge clock);
        #1 read_enable = 1'b0;
        repeat (p - p / 2 - 4) @(posedge clock);
      end else begin
        repeat (p - 1) @(posedge clock);
      end
    end
  endtask

  task automatic idleLine(input int cycles);
    @(posedge clock); #1 data_in = 1'b1;
    repeat (cycles) @(posedge clock);
  endtask

  // Frame-level receive rules applied to the model
  task automatic modelFrame(input logic [7:0] value, input logic stop_bit,
                            input bit read_at_stop);
    bit can_read;
    can_read = read_at_stop && (exp_q.size() > 0);
    if (!stop_bit) begin
      exp_fe++;
      if (can_read) void'(exp_q.pop_front());
    end else if (exp_q.size() < 64 || can_read) begin
      if (can_read) void'(exp_q.pop_front());
      exp_q.push_back(value);
    end else begin
      exp_oe++;
    end
  endtask

  task automatic checkState(input string tag);
    int lim;
    @(negedge clock);
    lim = (buffer_full_threshold == 6'd0) ? 64 : int'(buffer_full_threshold);
    checkOutput({tag, "/empty"}, 32'(buffer_empty), 32'(exp_q.size() == 0));
    if (exp_q.size() > 0) checkOutput({tag, "/head"}, 32'(data), 32'(exp_q[0]));
    checkOutput({tag, "/full"}, 32'(buffer_full), 32'(exp_q.size() >= lim));
    checkOutput({tag, "/fe_cycles"}, 32'(fe_cycles), 32'(exp_fe));
    checkOutput({tag, "/fe_pulses"}, 32'(fe_pulses), 32'(exp_fe));
    checkOutput({tag, "/oe_cycles"}, 32'(oe_cycles), 32'(exp_oe));
    checkOutput({tag, "/oe_pulses"}, 32'(oe_pulses), 32'(exp_oe));
  endtask

  task automatic drainAndCheck(input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      checkOutput($sformatf("%s/nonempty%0d", tag, i), 32'(buffer_empty), 32'(0));
      checkOutput($sformatf("%s/data%0d", tag, i), 32'(data), 32'(exp_q[0]));
      @(posedge clock); #1 read_enable = 1'b1;
      @(posedge clock); #1 read_enable = 1'b0;
      void'(exp_q.pop_front());
    end
    checkState({tag, "/drained"});
  endtask

  initial begin
    // Reset state while reset is held low
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset/data", 32'(data), 32'(0));
    checkOutput("reset/empty", 32'(buffer_empty), 32'(1));
    checkOutput("reset/full", 32'(buffer_full), 32'(0));
    checkOutput("reset/fe", 32'(framing_error), 32'(0));
    checkOutput("reset/oe", 32'(overrun_error), 32'(0));
    @(posedge clock); #1 reset = 1'b1;
    idleLine(5);

    // Single frame at 115200
    applyStimulus(8'hA5, 2'd3, 1'b1, 2'd3, 1'b0);
    modelFrame(8'hA5, 1'b1, 1'b0);
    checkState("a5");
    drainAndCheck("a5");

    // Back-to-back at 9600 with select toggled mid-frame
    applyStimulus(8'h3C, 2'd0, 1'b1, 2'd3, 1'b0);
    modelFrame(8'h3C, 1'b1, 1'b0);
    applyStimulus(8'hC3, 2'd0, 1'b1, 2'd3, 1'b0);
    modelFrame(8'hC3, 1'b1, 1'b0);
    checkState("b2b");
    drainAndCheck("b2b");

    // 3-cycle glitch at 57600 is rejected as a false start
    idleLine(5);
    baudrate_select = 2'd2;
    @(posedge clock); #1 data_in = 1'b0;
    repeat (3) @(posedge clock);
    #1 data_in = 1'b1;
    repeat (60) @(posedge clock);
    checkState("glitch");
    applyStimulus(8'h96, 2'd2, 1'b1, 2'd2, 1'b0);
    modelFrame(8'h96, 1'b1, 1'b0);
    checkState("post_glitch");
    drainAndCheck("post_glitch");

    // Framing error then recovery
    applyStimulus(8'h55, 2'd3, 1'b0, 2'd3, 1'b0);
    modelFrame(8'h55, 1'b0, 1'b0);
    idleLine(20);
    checkState("framing");
    applyStimulus(8'h0F, 2'd3, 1'b1, 2'd3, 1'b0);
    modelFrame(8'h0F, 1'b1, 1'b0);
    checkState("post_framing");
    drainAndCheck("post_framing");

    // Threshold 4, then threshold 0 (=64), overrun, write-with-read at full
    buffer_full_threshold = 6'd4;
    for (int i = 0; i < 4; i++) begin
      v = 8'($urandom);
      applyStimulus(v, 2'd3, 1'b1, 2'd3, 1'b0);
      modelFrame(v, 1'b1, 1'b0);
      checkState($sformatf("thr4_%0d", i));
    end
    buffer_full_threshold = 6'd0;
    checkState("thr0_4");
    for (int i = 0; i < 60; i++) begin
      v = 8'($urandom);
      applyStimulus(v, 2'd3, 1'b1, 2'd3, 1'b0);
      modelFrame(v, 1'b1, 1'b0);
    end
    checkState("fill64");
    applyStimulus(8'hEE, 2'd3, 1'b1, 2'd3, 1'b0);
    modelFrame(8'hEE, 1'b1, 1'b0);
    checkState("overrun");
    applyStimulus(8'h7D, 2'd3, 1'b1, 2'd3, 1'b1);
    modelFrame(8'h7D, 1'b1, 1'b1);
    checkState("full_rw");
    drainAndCheck("full64");

    // Reset mid-frame clears the FIFO silently
    buffer_full_threshold = 6'd4;
    applyStimulus(8'h11, 2'd3, 1'b1, 2'd3, 1'b0);
    modelFrame(8'h11, 1'b1, 1'b0);
    checkState("pre_reset");
    @(posedge clock); #1 data_in = 1'b0;
    repeat (10) @(posedge clock);
    #1 data_in = 1'b1;
    repeat (25) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    exp_q.delete();
    repeat (120) @(posedge clock);
    checkState("after_reset");
    applyStimulus(8'h81, 2'd3, 1'b1, 2'd3, 1'b0);
    modelFrame(8'h81, 1'b1, 1'b0);
    checkState("post_reset");
    drainAndCheck("post_reset");

    // Random byte streams at every rate
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 16; i++) begin
        v = 8'($urandom);
        applyStimulus(v, 2'(s), 1'b1, 2'(s), 1'b0);
        modelFrame(v, 1'b1, 1'b0);
      end
      checkState($sformatf("rand_sel%0d", s));
      drainAndCheck($sformatf("rand_sel%0d", s));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel stage downstream of the UART transmitter: consumes the transmitter's data_out line and recovers 8N1 frames (LSB first) at one of four selectable baud rates. Recovered bytes go into a 64-entry receive FIFO with a programmable fullness threshold. The block mirrors the transmitter's control interface, so a loopback bench connects the two directly.

Parameters:
CLOCK_FREQUENCY, 50_000_000, system clock in Hz; clocks-per-bit = CLOCK_FREQUENCY / baud, integer-truncated.
FIFO_DEPTH, 64, receive buffer entries; fixed at 64 to match the 6-bit threshold.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
data_in  input  1  serial line, idle high; asynchronous to clock
read_enable  input  1  pop FIFO head at this rising edge
buffer_full_threshold  input  6  fullness threshold; 0 means 64
baudrate_select  input  2  0=9600, 1=19200, 2=57600, 3=115200
data  output  8  FIFO head (show-ahead); valid when buffer_empty=0
buffer_empty  output  1  FIFO count == 0
buffer_full  output  1  FIFO count >= threshold
framing_error  output  1  one-cycle pulse: stop bit sampled 0, byte discarded
overrun_error  output  1  one-cycle pulse: byte completed while FIFO held 64, byte dropped

Behaviour:
- Reset (reset=0 at a rising edge): FSM=IDLE, counters=0, FIFO emptied, synchronizer flops=1. Outputs: data=0, buffer_empty=1, buffer_full=0 (threshold>0), framing_error=0, overrun_error=0.
- data_in passes through a 2-flop synchronizer. Only the synchronized value (rx) is used.
- IDLE: a 1->0 transition on rx latches baudrate_select into a period register P, loads half = P/2, and moves to START. A baudrate_select change mid-frame has no effect until the next start.
- START: count half cycles, then sample rx. If rx=1 (false start), go to IDLE. Otherwise go to DATA with bit index 0.
- DATA: every P cycles, sample rx into shift-register bit[index], LSB first. After index 7, go to STOP.
- STOP: after P cycles (mid stop bit), sample rx.
  - rx=1 and FIFO count < 64: write the byte.
  - rx=1 and FIFO count = 64: pulse overrun_error, drop the byte.
  - rx=0: pulse framing_error, discard the byte.
  - In every case go to IDLE the same cycle, so resync is possible within the second half of the stop bit.
- Error pulses are high for exactly the cycle after the STOP sample edge.
- Write latency: the byte enters the FIFO at the STOP sample edge; buffer_empty falls and data updates on that same edge (registered outputs).
- FIFO:
  - read_enable when empty is ignored.
  - Simultaneous read and write: both occur, count unchanged. This also holds at count=64, where the write is accepted because a read frees a slot that cycle.
  - Pointers are 6 bits and wrap modulo 64. Count is 7 bits.
- buffer_full = (count >= (threshold==0 ? 64 : threshold)). It is recomputed combinationally from registered count and the live threshold input.
- Reset mid-frame aborts the frame silently (no error pulse) and clears the FIFO.

Decomposition:
- Package uart_receiver_package:
  - state enum (IDLE, START, DATA, STOP)
  - baud table constant: 4-entry array of baud rates
  - function clocks_per_bit(select, freq)
  - FIFO_DEPTH and pointer-width constants
- Sub-module uart_receiver_fifo: synchronous show-ahead FIFO, 8-bit x 64, with count, threshold compare, overrun-free write-when-read-at-full. Reused by a later transmit-path rework.

Test Plan:
All scenarios use CLOCK_FREQUENCY=1_152_000, giving P = 120/60/20/10 for selects 0-3.
- Select 3, send frame for 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> after ~95 clocks buffer_empty=0, data=0xA5; one read_enable -> buffer_empty=1.
- Select 0, send 0x3C then 0xC3 back-to-back; change baudrate_select to 3 mid-frame -> both bytes correct in order; no error pulses.
- Select 2, 3-clock low glitch on data_in -> FSM returns to IDLE, FIFO empty, no error pulses.
- Select 3, frame 0x55 with stop bit 0 -> framing_error high exactly 1 cycle; FIFO stays empty; next valid frame 0x0F received correctly.
- Threshold=4, send 4 bytes -> buffer_full rises when the 4th byte is written; threshold=0 with 64 bytes -> buffer_full=1; 65th byte -> overrun_error pulse, FIFO content unchanged; 65th byte with read_enable on the write cycle -> accepted, count stays 64.
- Assert reset mid-DATA of 0xFF -> buffer_empty=1, no error pulse; next frame 0x81 received correctly.
- Loopback with uart_transmitter: 16 random bytes at each select -> identical sequence on receiver data.
